// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the key pulse front end.
// Direction bit indices for move_n / key_stable_n and per-channel FSM state encoding.
// No logic here, constants only.
package key_pulse_gen_pkg;

  // Bit positions of each direction on the key/move buses
  localparam int KEY_LEFT  = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_RIGHT = 3;

  // Per-key FSM states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

endpackage

// File: rtl/key_pulse_gen_key_channel.sv
// One key: 2-FF sync, debounce and press/auto-repeat pulse FSM.
// Latency: stable level and press pulse appear DEBOUNCE_CYCLES+2 edges after a held change.
// No backpressure: pulses are fire-and-forget, one cycle wide, never back to back.
module key_channel
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic move_n_o,
  output logic key_stable_n_o
);

  localparam int MAXR = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(MAXR + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic          REP_EN   = (REPEAT_DELAY != 0);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          move_n_q, move_n_d;
  logic          press, released;
  logic          dly_hit, per_hit;

  // Synchronizer, debounce state, FSM state and registered pulse output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      dcnt_q   <= '0;
      state_q  <= IDLE;
      rcnt_q   <= '0;
      move_n_q <= 1'b1;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      move_n_q <= move_n_d;
    end
  end

  // Debounce: count consecutive cycles of disagreement, commit on the last one
  always_comb begin
    stable_d = stable_q;
    dcnt_d   = '0;
    if (sync2_q != stable_q) begin
      if (dcnt_q == DB_LAST) begin
        stable_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Press/release are judged on the level being committed this edge, so a release
  // that lands on a repeat slot wins and suppresses that pulse.
  assign press    = stable_q & ~stable_d;
  assign released = stable_d;
  // A slot only fires when the previous cycle was idle, keeping pulses separated;
  // otherwise the counter parks on the slot for one cycle.
  assign dly_hit  = REP_EN && (rcnt_q == DLY_LAST) && move_n_q;
  assign per_hit  = (rcnt_q == PER_LAST) && move_n_q;

  // Next-state and repeat counter
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = HOLD;
          rcnt_d  = '0;
        end
      end
      HOLD: begin
        if (released) begin
          state_d = IDLE;
        end else if (REP_EN) begin
          if (rcnt_q == DLY_LAST) begin
            if (dly_hit) begin
              state_d = REPEAT;
              rcnt_d  = '0;
            end
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      REPEAT: begin
        if (released) begin
          state_d = IDLE;
        end else if (rcnt_q == PER_LAST) begin
          if (per_hit) begin
            rcnt_d = '0;
          end
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  // Pulse output: press in IDLE, delay/period slot in HOLD/REPEAT
  always_comb begin
    move_n_d = 1'b1;
    case (state_q)
      IDLE:    if (press) move_n_d = 1'b0;
      HOLD:    if (!released && dly_hit) move_n_d = 1'b0;
      REPEAT:  if (!released && per_hit) move_n_d = 1'b0;
      default: move_n_d = 1'b1;
    endcase
  end

  assign move_n_o       = move_n_q;
  assign key_stable_n_o = stable_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Cursor-move front end: N_KEYS independent debounced press/auto-repeat pulse channels.
// Latency: DEBOUNCE_CYCLES+2 edges from a held key change to key_stable_n / press pulse.
// No backpressure; coincident pulses on several bits are passed through unarbitrated.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] move_n,
  output logic [N_KEYS-1:0] key_stable_n
);

  // One channel per key, no shared state
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .key_n_i       (key_n[i]),
      .move_n_o      (move_n[i]),
      .key_stable_n_o(key_stable_n[i])
    );
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change and outputs are sampled on the falling edge; "edge k" is the k-th rising
// edge after the input change.
module tb_key_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] move_n;
  logic [3:0] key_stable_n;

  int n_assert = 0;
  int n_fail   = 0;

  key_pulse_gen #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .move_n      (move_n),
    .key_stable_n(key_stable_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_mv;
    logic [3:0] exp_st;

    // 1: reset with all keys released
    rst   = 1'b1;
    key_n = 4'b1111;
    for (int e = 1; e <= 2; e++) begin
      step();
      chk($sformatf("rst_move_%0d", e), move_n, 4'b1111);
      chk($sformatf("rst_stable_%0d", e), key_stable_n, 4'b1111);
    end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk($sformatf("idle_move_%0d", e), move_n, 4'b1111);
    end

    // 2: press key 0, commit and pulse at edge 6 only
    key_n = 4'b1110;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_mv = (e == 6) ? 4'b1110 : 4'b1111;
      exp_st = (e >= 6) ? 4'b1110 : 4'b1111;
      chk($sformatf("press0_move_e%0d", e), move_n, exp_mv);
      chk($sformatf("press0_stable_e%0d", e), key_stable_n, exp_st);
    end
    // release key 0 before its first repeat slot: no pulse
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_st = (e >= 6) ? 4'b1111 : 4'b1110;
      chk($sformatf("rel0_move_e%0d", e), move_n, 4'b1111);
      chk($sformatf("rel0_stable_e%0d", e), key_stable_n, exp_st);
    end

    // 3: bounce on key 1, never 4 consecutive low samples
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        key_n = (c < 3) ? 4'b1101 : 4'b1111;
        step();
        chk($sformatf("bounce_move_r%0d_c%0d", r, c), move_n, 4'b1111);
        chk($sformatf("bounce_stable_r%0d_c%0d", r, c), key_stable_n, 4'b1111);
      end
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk($sformatf("bounce_settle_e%0d", e), key_stable_n, 4'b1111);
    end

    // 4: hold key 3 for 40 edges: press at 6, repeats at 16,19,...,40
    key_n = 4'b0111;
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_mv = ((e == 6) || (e >= 16 && (e - 16) % 3 == 0)) ? 4'b0111 : 4'b1111;
      exp_st = (e >= 6) ? 4'b0111 : 4'b1111;
      chk($sformatf("hold3_move_e%0d", e), move_n, exp_mv);
      chk($sformatf("hold3_stable_e%0d", e), key_stable_n, exp_st);
    end
    // release: key still debounced-pressed at 43 (repeat), release commits at 46
    // which coincides with a repeat slot and must suppress it
    key_n = 4'b1111;
    for (int e = 41; e <= 52; e++) begin
      step();
      exp_mv = (e == 43) ? 4'b0111 : 4'b1111;
      exp_st = (e >= 46) ? 4'b1111 : 4'b0111;
      chk($sformatf("rel3_move_e%0d", e), move_n, exp_mv);
      chk($sformatf("rel3_stable_e%0d", e), key_stable_n, exp_st);
    end

    // 5: keys 0 and 3 together -> coincident pulse 0110 for one cycle
    key_n = 4'b0110;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_mv = (e == 6) ? 4'b0110 : 4'b1111;
      exp_st = (e >= 6) ? 4'b0110 : 4'b1111;
      chk($sformatf("dual_move_e%0d", e), move_n, exp_mv);
      chk($sformatf("dual_stable_e%0d", e), key_stable_n, exp_st);
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("dual_rel_move_e%0d", e), move_n, 4'b1111);
    end

    // 6: hold key 2 into REPEAT, reset on the edge where a repeat (19) would fire
    key_n = 4'b1011;
    for (int e = 1; e <= 18; e++) begin
      step();
      exp_mv = (e == 6 || e == 16) ? 4'b1011 : 4'b1111;
      chk($sformatf("hold2_move_e%0d", e), move_n, exp_mv);
    end
    rst = 1'b1;
    step();
    chk("rst_mid_move", move_n, 4'b1111);
    chk("rst_mid_stable", key_stable_n, 4'b1111);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step();
      exp_mv = (e == 6) ? 4'b1011 : 4'b1111;
      exp_st = (e >= 6) ? 4'b1011 : 4'b1111;
      chk($sformatf("repress2_move_e%0d", e), move_n, exp_mv);
      chk($sformatf("repress2_stable_e%0d", e), key_stable_n, exp_st);
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      step();
    end
    chk("final_move", move_n, 4'b1111);
    chk("final_stable", key_stable_n, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
